// File: rtl/quadrature_input_conditioner.sv
// Encoder front end: per-channel synchronizer and glitch filter for A/B/index,
// startup settle timer, and illegal A/B transition detection with error tracking.
module quadrature_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rawA,
  input  logic                 rawB,
  input  logic                 rawIdx,
  input  logic                 clearErr,
  output logic                 sigA,
  output logic                 sigB,
  output logic                 sigIdx,
  output logic                 ready,
  output logic                 illegalPulse,
  output logic                 errorSticky,
  output logic [ERR_WIDTH-1:0] errorCount
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam int SETTLE = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int SETTLE_W = $clog2(SETTLE);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  // Channel bit order throughout: [0]=A, [1]=B, [2]=index.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  sync_s;
  logic [2:0]                  filt_q;
  logic [2:0][CNT_W-1:0]       filt_cnt;
  logic [SETTLE_W-1:0]         settle_cnt;
  logic                        prev_a;
  logic                        prev_b;
  logic                        illegal_det;

  // NOTE: the synchronizer chain is a small register array, but it is still
  // reset explicitly so every flop starts from a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what forms the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], {rawIdx, rawB, rawA}};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Output follows the synchronized level only after FILTER_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      filt_cnt <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        if (sync_s[ch] == filt_q[ch]) begin
          filt_cnt[ch] <= '0;
        end else if (filt_cnt[ch] == CNT_LAST) begin
          filt_q[ch]   <= sync_s[ch];
          filt_cnt[ch] <= '0;
        end else begin
          filt_cnt[ch] <= filt_cnt[ch] + 1'b1;
        end
      end
    end
  end

  assign sigA   = filt_q[0];
  assign sigB   = filt_q[1];
  assign sigIdx = filt_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else if (!ready) begin
      if (settle_cnt == SETTLE_LAST) begin
        ready <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // Pre-edge ready masks the startup 00->11 jump, which is seen on the same
  // edge that ready rises.
  assign illegal_det = ready && (sigA != prev_a) && (sigB != prev_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a       <= 1'b0;
      prev_b       <= 1'b0;
      illegalPulse <= 1'b0;
      errorSticky  <= 1'b0;
      errorCount   <= '0;
    end else begin
      prev_a       <= sigA;
      prev_b       <= sigB;
      illegalPulse <= illegal_det;
      if (illegal_det) begin
        errorSticky <= 1'b1;
        if (clearErr) begin
          errorCount <= ERR_WIDTH'(1);
        end else if (errorCount != '1) begin
          errorCount <= errorCount + 1'b1;
        end
      end else if (clearErr) begin
        errorSticky <= 1'b0;
        errorCount  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_input_conditioner.sv
// Directed bench for quadrature_input_conditioner: a default instance plus an
// ERR_WIDTH=2 instance sharing the same stimulus for the saturation checks.
module tb_quadrature_input_conditioner;

  logic clk;
  logic rst_n;
  logic rawA;
  logic rawB;
  logic rawIdx;
  logic clearErr;

  logic        sigA, sigB, sigIdx, ready, illegalPulse, errorSticky;
  logic [15:0] errorCount;
  logic        sigA_e, sigB_e, sigIdx_e, ready_e, illegalPulse_e, errorSticky_e;
  logic [1:0]  errorCount_e;

  int vectors;
  int miscompares;

  quadrature_input_conditioner dut (
    .clk(clk), .rst_n(rst_n), .rawA(rawA), .rawB(rawB), .rawIdx(rawIdx),
    .clearErr(clearErr), .sigA(sigA), .sigB(sigB), .sigIdx(sigIdx),
    .ready(ready), .illegalPulse(illegalPulse), .errorSticky(errorSticky),
    .errorCount(errorCount)
  );

  quadrature_input_conditioner #(.ERR_WIDTH(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .rawA(rawA), .rawB(rawB), .rawIdx(rawIdx),
    .clearErr(clearErr), .sigA(sigA_e), .sigB(sigB_e), .sigIdx(sigIdx_e),
    .ready(ready_e), .illegalPulse(illegalPulse_e), .errorSticky(errorSticky_e),
    .errorCount(errorCount_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Release reset with rawA=rawB=1 already applied; checks edges 1..9.
  task automatic check_startup(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      vectors++;
      if ({sigA, sigB} !== {2{i >= 6}}) begin
        miscompares++;
        $display("FAIL %s sigAB edge %0d: got %b want %b", tag, i, {sigA, sigB}, {2{i >= 6}});
      end
      vectors++;
      if (ready !== (i >= 7)) begin
        miscompares++;
        $display("FAIL %s ready edge %0d: got %b want %b", tag, i, ready, (i >= 7));
      end
      vectors++;
      if (illegalPulse !== 1'b0 || errorCount !== 16'd0) begin
        miscompares++;
        $display("FAIL %s err edge %0d: got pulse=%b cnt=%0d want 0/0", tag, i, illegalPulse, errorCount);
      end
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    rawA = a; rawB = b; rawIdx = 1'b0; clearErr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL do_reset ready: got %b want 1", ready);
    end
  endtask

  // Drive a new A/B level and follow it for 10 edges: latency 6, optional
  // illegal pulse on edge 7, optional clearErr coinciding with that event.
  task automatic apply_ab(input logic a, input logic b, input logic exp_ill, input logic clr_at_event);
    logic [1:0] old_ab;
    logic [1:0] exp_ab;
    old_ab = {sigA, sigB};
    rawA = a; rawB = b;
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      exp_ab = (j >= 5) ? {a, b} : old_ab;
      vectors++;
      if ({sigA, sigB} !== exp_ab) begin
        miscompares++;
        $display("FAIL ab_step %b%b j=%0d: got %b want %b", a, b, j, {sigA, sigB}, exp_ab);
      end
      vectors++;
      if (illegalPulse !== (exp_ill && j == 6)) begin
        miscompares++;
        $display("FAIL ab_pulse %b%b j=%0d: got %b want %b", a, b, j, illegalPulse, (exp_ill && j == 6));
      end
      if (clr_at_event && j == 5) clearErr = 1'b1;
      if (j == 6) clearErr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rawA = 1'b1; rawB = 1'b1; rawIdx = 1'b0; clearErr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sigA, sigB, sigIdx, ready, illegalPulse, errorSticky} !== 6'b0 || errorCount !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b cnt=%0d want 000000 cnt=0",
               {sigA, sigB, sigIdx, ready, illegalPulse, errorSticky}, errorCount);
    end
    check_startup("startup");
  endtask

  task automatic test_glitch();
    do_reset(1'b0, 1'b0);
    // 3-cycle glitch must never reach sigA.
    rawA = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 2) rawA = 1'b0;
      vectors++;
      if (sigA !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch3 j=%0d: got %b want 0", j, sigA);
      end
    end
    // 4-cycle pulse is the minimum that passes: high after edges 5..8.
    rawA = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 3) rawA = 1'b0;
      vectors++;
      if (sigA !== (j >= 5 && j <= 8)) begin
        miscompares++;
        $display("FAIL pass4 j=%0d: got %b want %b", j, sigA, (j >= 5 && j <= 8));
      end
    end
  endtask

  task automatic test_index();
    rawIdx = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 3) rawIdx = 1'b0;
      vectors++;
      if (sigIdx !== (j >= 5 && j <= 8) || illegalPulse !== 1'b0) begin
        miscompares++;
        $display("FAIL index j=%0d: got idx=%b pulse=%b want idx=%b pulse=0",
                 j, sigIdx, illegalPulse, (j >= 5 && j <= 8));
      end
    end
  endtask

  task automatic test_gray();
    apply_ab(1'b0, 1'b1, 1'b0, 1'b0);
    apply_ab(1'b1, 1'b1, 1'b0, 1'b0);
    apply_ab(1'b1, 1'b0, 1'b0, 1'b0);
    apply_ab(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (errorSticky !== 1'b0 || errorCount !== 16'd0) begin
      miscompares++;
      $display("FAIL gray_errs: got sticky=%b cnt=%0d want 0/0", errorSticky, errorCount);
    end
  endtask

  task automatic test_illegal();
    rawA = 1'b1; rawB = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      vectors++;
      if ({sigA, sigB} !== {2{j >= 5}} || illegalPulse !== (j == 6)) begin
        miscompares++;
        $display("FAIL illegal j=%0d: got ab=%b pulse=%b want ab=%b pulse=%b",
                 j, {sigA, sigB}, illegalPulse, {2{j >= 5}}, (j == 6));
      end
      vectors++;
      if (errorSticky !== (j >= 6) || errorCount !== ((j >= 6) ? 16'd1 : 16'd0)) begin
        miscompares++;
        $display("FAIL illegal_err j=%0d: got sticky=%b cnt=%0d want %b/%0d",
                 j, errorSticky, errorCount, (j >= 6), (j >= 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    logic t;
    @(negedge clk); clearErr = 1'b1;
    @(negedge clk); clearErr = 1'b0;
    vectors++;
    if (errorCount_e !== 2'd0 || errorSticky_e !== 1'b0 || errorCount !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_clear0: got e=%0d/%b cnt=%0d want 0/0 0", errorCount_e, errorSticky_e, errorCount);
    end
    for (int i = 1; i <= 5; i++) begin
      t = (i % 2 == 0);
      apply_ab(t, t, 1'b1, 1'b0);
      vectors++;
      if (errorCount_e !== 2'((i > 3) ? 3 : i) || errorCount !== 16'(i)) begin
        miscompares++;
        $display("FAIL sat_count %0d: got e=%0d cnt=%0d want e=%0d cnt=%0d",
                 i, errorCount_e, errorCount, (i > 3) ? 3 : i, i);
      end
    end
    apply_ab(1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (errorCount_e !== 2'd1 || errorSticky_e !== 1'b1 || errorCount !== 16'd1) begin
      miscompares++;
      $display("FAIL sat_event_wins: got e=%0d/%b cnt=%0d want 1/1 1", errorCount_e, errorSticky_e, errorCount);
    end
    @(negedge clk); clearErr = 1'b1;
    @(negedge clk); clearErr = 1'b0;
    vectors++;
    if (errorCount_e !== 2'd0 || errorSticky_e !== 1'b0 || errorSticky !== 1'b0 || {sigA, sigB} !== 2'b11) begin
      miscompares++;
      $display("FAIL sat_clear: got e=%0d/%b sticky=%b ab=%b want 0/0 0 11",
               errorCount_e, errorSticky_e, errorSticky, {sigA, sigB});
    end
  endtask

  task automatic test_mid_reset();
    apply_ab(1'b0, 1'b0, 1'b1, 1'b0);
    rawB = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    rawA = 1'b1;
    #1;
    vectors++;
    if (sigB !== 1'b0 || ready !== 1'b0 || errorCount !== 16'd0 || errorSticky !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got sigB=%b ready=%b cnt=%0d sticky=%b want 0 0 0 0",
               sigB, ready, errorCount, errorSticky);
    end
    @(negedge clk);
    check_startup("restart");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_glitch();
    test_index();
    test_gray();
    test_illegal();
    test_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quadrature_input_conditioner.md
Name: quadrature_input_conditioner

Overview:
- Conditions raw encoder pins before the quadrature counter stage.
- Per channel (A, B, index): multi-flop synchronizer, then a counter-based glitch filter.
- Produces clean, synchronized sigA/sigB/sigIdx that the counter consumes directly.
- Also detects illegal quadrature transitions (both channels changing in one cycle) and tracks them with a pulse, a sticky flag and a saturating error counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel; legal range 2..4.
- FILTER_CYCLES, 4, consecutive cycles a synchronized value must differ from the filtered output before the output takes it; legal range 1..255.
- ERR_WIDTH, 16, width of errorCount.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- rawA  input  1  unsynchronized encoder channel A.
- rawB  input  1  unsynchronized encoder channel B.
- rawIdx  input  1  unsynchronized index pulse.
- clearErr  input  1  synchronous clear of errorSticky and errorCount.
- sigA  output  1  filtered, synchronized A.
- sigB  output  1  filtered, synchronized B.
- sigIdx  output  1  filtered, synchronized index.
- ready  output  1  high once the startup settle period has elapsed.
- illegalPulse  output  1  one-cycle strobe on an illegal A/B transition.
- errorSticky  output  1  set by an illegal transition; held until clearErr.
- errorCount  output  ERR_WIDTH  saturating count of illegal transitions.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All registers clear on assertion.
- Reset values: sync flops, filter counters, sigA, sigB, sigIdx, ready, illegalPulse, errorSticky = 0; errorCount = 0.
- Reset release is taken on the next clk edge; there is no reset synchronizer inside the block.
- Synchronizer: s = last flop of an SYNC_STAGES-deep chain clocked by clk.
- Filter, per channel, each edge:
  - if s == out: cnt <= 0.
  - else if cnt == FILTER_CYCLES-1: out <= s, cnt <= 0.
  - else: cnt <= cnt+1.
  - Any sample equal to out during counting restarts the count; glitches shorter than FILTER_CYCLES cycles never reach the output.
- Counter width is ceil(log2(FILTER_CYCLES)), minimum 1.
- Latency: a raw level stable from edge k appears on the output after edge k+SYNC_STAGES+FILTER_CYCLES-1. With defaults, 6 edges after first sampling.
- Minimum pass width: FILTER_CYCLES cycles at s.
- Startup: a settle counter runs after reset release. ready rises after SYNC_STAGES+FILTER_CYCLES+1 edges and stays high until reset.
- Illegal-transition detection:
  - Trigger: sigA and sigB both change on the same edge, i.e. {prevA,prevB} to {sigA,sigB} differ in both bits.
  - Masked while ready=0, so startup settling of 00 to 11 is not flagged.
  - illegalPulse is registered: high for exactly one cycle, on the cycle after the sig outputs change.
  - Same edge as illegalPulse: errorSticky <= 1, and errorCount increments, saturating at all-ones with no wrap.
- Index: filtered only; it does not take part in illegal detection.
- clearErr: synchronous. It zeroes errorSticky and errorCount.
  - If clearErr coincides with a new illegal event, the event wins: errorCount = 1, errorSticky = 1.
  - clearErr has no effect on the filters or ready.
- Reset mid-operation: all state returns to reset values immediately; ready drops; in-progress filter counts are discarded.

Test Plan:
1. Defaults; reset; hold rawA=1, rawB=1 from release -> ready rises on edge 7 after release; sigA=sigB=1 after edge 6; illegalPulse never asserts; errorCount=0.
2. Defaults, after ready; rawA glitch high for 3 cycles, then low -> sigA stays 0 throughout. Then rawA high for 4 cycles -> sigA=1 exactly 6 edges after first high sample.
3. After ready; step rawA/rawB through the Gray sequence 00,01,11,10,00, each level held 10 cycles -> each transition appears at sig outputs with latency 6; no illegalPulse.
4. After ready, {sigA,sigB}=00; drive rawA=rawB=1 on the same edge -> both outputs change on the same edge; illegalPulse high one cycle later for one cycle; errorSticky=1; errorCount=1.
5. ERR_WIDTH=2; generate 5 illegal transitions -> errorCount sequence 1,2,3,3,3. Then assert clearErr on the same cycle as a 6th event -> errorCount=1, errorSticky=1. Then clearErr alone -> 0, 0.
6. Mid-count reset: rawB high 2 cycles into filtering, assert rst_n=0 asynchronously -> sigB, cnt, ready, errorCount = 0 immediately. After release, behaviour is identical to scenario 1 timing.
